// File: rtl/stream_elastic_fifo.sv
// Elastic valid/ready FIFO of DEPTH entries. Every output is a flop, and the
// head entry is kept in a register so there is no A-to-B combinational path.
module stream_elastic_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AFULL = DEPTH - 1,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM,
  output logic             oReady_AM,
  input  logic [WIDTH-1:0] iData_AM,
  output logic             oValid_BM,
  input  logic             iReady_BM,
  output logic [WIDTH-1:0] oData_BM,
  input  logic             iFlush,
  output logic [CW-1:0]    oCount,
  output logic             oAlmostFull
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtrNext;
  logic [PW-1:0]    rdPtrNext;
  logic [CW-1:0]    countNext;
  logic [WIDTH-1:0] headNext;
  logic             put;
  logic             get;

  function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign put = iValid_AM && oReady_AM;
  assign get = oValid_BM && iReady_BM;

  // Next pointers, count and head; count is the sole source of full/empty.
  always_comb begin
    wrPtrNext = wrPtr;
    rdPtrNext = rdPtr;
    countNext = oCount;
    headNext  = oData_BM;
    if (iFlush) begin
      wrPtrNext = '0;
      rdPtrNext = '0;
      countNext = '0;
    end else begin
      if (put) wrPtrNext = incPtr(wrPtr);
      if (get) rdPtrNext = incPtr(rdPtr);
      if (put && !get)      countNext = oCount + CW'(1);
      else if (get && !put) countNext = oCount - CW'(1);
      // The next head is the beat being written now when it lands at the read slot.
      headNext = (put && (wrPtr == rdPtrNext)) ? iData_AM : mem[rdPtrNext];
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      oCount      <= '0;
      oReady_AM   <= 1'b1;
      oValid_BM   <= 1'b0;
      oAlmostFull <= 1'b0;
      oData_BM    <= '0;
    end else begin
      wrPtr       <= wrPtrNext;
      rdPtr       <= rdPtrNext;
      oCount      <= countNext;
      oReady_AM   <= (countNext != CW'(DEPTH));
      oValid_BM   <= (countNext != '0);
      oAlmostFull <= (countNext >= CW'(AFULL));
      oData_BM    <= headNext;
    end
  end

  // Storage needs no reset; its contents are meaningless until written.
  always_ff @(posedge iCLK) begin
    if (put && !iFlush) mem[wrPtr] <= iData_AM;
  end

endmodule

// File: tb/tb_stream_elastic_fifo.sv
// Directed and scoreboarded checks for stream_elastic_fifo (DEPTH=4 and DEPTH=3).
module tb_stream_elastic_fifo;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;

  // DEPTH=4, AFULL=3 instance
  logic       vA = 1'b0;
  logic [7:0] dA = 8'h00;
  logic       rB = 1'b0;
  logic       flush = 1'b0;
  logic       readyA;
  logic       validB;
  logic [7:0] dataB;
  logic [2:0] count4;
  logic       afull4;

  // DEPTH=3 instance for wrap-around
  logic       v3 = 1'b0;
  logic [7:0] d3 = 8'h00;
  logic       r3 = 1'b0;
  logic       flush3 = 1'b0;
  logic       ready3;
  logic       valid3;
  logic [7:0] data3;
  logic [1:0] count3;
  logic       afull3;

  int checks = 0;
  int failures = 0;

  always #5 iCLK = ~iCLK;

  stream_elastic_fifo #(.WIDTH(8), .DEPTH(4), .AFULL(3)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AM(vA), .oReady_AM(readyA), .iData_AM(dA),
    .oValid_BM(validB), .iReady_BM(rB), .oData_BM(dataB),
    .iFlush(flush), .oCount(count4), .oAlmostFull(afull4)
  );

  stream_elastic_fifo #(.WIDTH(8), .DEPTH(3), .AFULL(2)) dut3 (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AM(v3), .oReady_AM(ready3), .iData_AM(d3),
    .oValid_BM(valid3), .iReady_BM(r3), .oData_BM(data3),
    .iFlush(flush3), .oCount(count3), .oAlmostFull(afull3)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic checkState(input string tag, input int c, input int v, input int r, input int af);
    check({tag, " count"}, int'(count4), c);
    check({tag, " valid"}, int'(validB), v);
    check({tag, " ready"}, int'(readyA), r);
    check({tag, " afull"}, int'(afull4), af);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       f;
    int         eCount;
    logic       eValid;
    logic       eReady;
    logic       eAf;
    logic       chkD;
    logic [7:0] eData;
  } vec_t;

  vec_t vecs [18];

  initial begin
    int q [$];
    int seq;
    int beats;
    int cyc;
    logic doPut;
    logic doGet;

    // fill, held 5th push, drain
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    // flush at count=2 with concurrent put of 0xAA and get
    vecs[9]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1};
    vecs[10] = '{1'b1, 8'hA2, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1};
    vecs[11] = '{1'b1, 8'hAA, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[13] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    // simultaneous put and get at count=1
    vecs[15] = '{1'b1, 8'hB1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hB1};
    vecs[16] = '{1'b1, 8'hB2, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hB2};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    repeat (2) @(negedge iCLK);
    checkState("reset", 0, 0, 1, 0);
    check("reset data", int'(dataB), 0);
    check("reset3 count", int'(count3), 0);
    iRST = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge iCLK);
      vA = vecs[i].v; dA = vecs[i].d; rB = vecs[i].r; flush = vecs[i].f;
      @(posedge iCLK);
      #1;
      checkState($sformatf("vec%0d", i), vecs[i].eCount, int'(vecs[i].eValid),
                 int'(vecs[i].eReady), int'(vecs[i].eAf));
      if (vecs[i].chkD) check($sformatf("vec%0d data", i), int'(dataB), int'(vecs[i].eData));
    end

    // streaming 0..99, one per cycle after a single-cycle latency
    for (int i = 0; i < 100; i++) begin
      @(negedge iCLK);
      vA = 1'b1; rB = 1'b1; flush = 1'b0; dA = 8'(i);
      @(posedge iCLK);
      #1;
      check($sformatf("stream%0d data", i), int'(dataB), i);
      check($sformatf("stream%0d count", i), int'(count4), 1);
      check($sformatf("stream%0d valid", i), int'(validB), 1);
    end
    @(negedge iCLK);
    vA = 1'b0;
    @(posedge iCLK);
    #1;
    checkState("stream end", 0, 0, 1, 0);

    // async reset at count=3, asserted between edges
    rB = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      vA = 1'b1; dA = 8'hC1 + 8'(i);
      @(posedge iCLK);
    end
    #1;
    check("pre-reset count", int'(count4), 3);
    vA = 1'b0;
    #1 iRST = 1'b1;
    #1;
    checkState("async reset", 0, 0, 1, 0);
    #1 iRST = 1'b0;
    @(negedge iCLK);
    vA = 1'b1; dA = 8'hD1;
    @(posedge iCLK);
    #1;
    checkState("post-reset put", 1, 1, 1, 0);
    check("post-reset data", int'(dataB), 8'hD1);
    @(negedge iCLK);
    vA = 1'b0;

    // DEPTH=3 random traffic against a queue model
    seq = 0;
    beats = 0;
    cyc = 0;
    while (beats < 1000 && cyc < 6000) begin
      @(negedge iCLK);
      v3 = 1'($urandom_range(0, 1));
      r3 = 1'($urandom_range(0, 1));
      d3 = 8'(seq);
      #1;
      doPut = v3 && ready3;
      doGet = valid3 && r3;
      if (doGet) begin
        check("wrap data", int'(data3), q.pop_front());
        beats++;
      end
      if (doPut) begin
        q.push_back(seq & 8'hFF);
        seq++;
      end
      @(posedge iCLK);
      #1;
      check("wrap count", int'(count3), q.size());
      check("wrap ready", int'(ready3), int'(q.size() != 3));
      check("wrap valid", int'(valid3), int'(q.size() != 0));
      cyc++;
    end
    check("wrap beats", beats, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_elastic_fifo.md
Name: stream_elastic_fifo

Overview:
- Parametrised successor to the single-slot stream register.
- Elastic buffer of DEPTH entries on a valid/ready stream. Full throughput of one transfer per cycle at any occupancy below full.
- Every output is driven only from flops, so there is no combinational path from the A side to the B side or back.
- Adds occupancy count, almost-full flag and synchronous flush. It sits between pipeline stages that need decoupling deeper than one beat, or credit-style backpressure.

Parameters:
- WIDTH, 64: data width in bits.
- DEPTH, 4: number of entries. Legal range 2..1024, any integer; power of two is not required.
- AFULL, DEPTH-1: oAlmostFull asserts when occupancy >= AFULL. Legal range 1..DEPTH.
- CW, $clog2(DEPTH+1): count width. Derived; callers must not override it.

Ports:
- iCLK, in, 1: clock. All logic is rising-edge.
- iRST, in, 1: asynchronous active-high reset.
- iValid_AM, in, 1: upstream valid.
- oReady_AM, out, 1: upstream ready; high when not full.
- iData_AM, in, WIDTH: upstream data.
- oValid_BM, out, 1: downstream valid; high when not empty.
- iReady_BM, in, 1: downstream ready.
- oData_BM, out, WIDTH: downstream data (head entry).
- iFlush, in, 1: synchronous discard of all contents.
- oCount, out, CW: current occupancy, 0..DEPTH.
- oAlmostFull, out, 1: high when occupancy >= AFULL.

Behaviour:
- Reset (asynchronous, while iRST=1):
  - count=0, write pointer=0, read pointer=0.
  - oValid_BM=0, oReady_AM=1, oAlmostFull=0, oCount=0, oData_BM=0.
  - Storage contents are don't-care.
- Reset release: first put is accepted on the first rising edge with iRST=0.
- Transfer definitions:
  - put = iValid_AM && oReady_AM.
  - get = oValid_BM && iReady_BM.
- Registered flags:
  - oReady_AM and oValid_BM are flops, updated from next-count: oReady_AM = (count != DEPTH), oValid_BM = (count != 0).
  - Both must equal those expressions in every cycle.
  - oAlmostFull is a flop equal to (count >= AFULL).
- Next count:
  - put only: +1.
  - get only: -1.
  - both, or neither: unchanged.
- Pointers:
  - Each pointer advances by 1 on its transfer.
  - Wrap: pointer at DEPTH-1 goes to 0.
  - Pointers are never compared to derive full/empty; count is authoritative.
- Data path:
  - Write stores iData_AM at the write pointer on put.
  - oData_BM is the entry at the read pointer, read from storage or a head register.
  - Insertion latency: put at edge N means oValid_BM=1 and oData_BM equals that data after edge N, i.e. one cycle. No same-cycle bypass.
- Stability: while oValid_BM=1 and iReady_BM=0, oData_BM and oValid_BM hold.
- Boundary cases:
  - Full (count=DEPTH): oReady_AM=0, so no put. A get that cycle frees one slot, and oReady_AM=1 next cycle. This gives a one-cycle bubble upstream, which is accepted because ready is registered.
  - Empty: oValid_BM=0, so no get. A put that cycle gives oValid_BM=1 next cycle.
  - Simultaneous put and get at count=1: head advances to the new data; count stays 1; oValid_BM stays 1.
- Flush (iFlush=1 at an edge):
  - Flush has priority. Any put or get in that cycle is discarded, and upstream or downstream must treat it as not transferred.
  - After the edge: count=0, both pointers=0, oValid_BM=0, oReady_AM=1, oAlmostFull=0.
  - oData_BM is don't-care.
- Reset mid-operation: asserting iRST immediately forces the reset values, with no clock required. All in-flight data is lost.
- Ordering: strict FIFO. No duplication or loss except by flush or reset.

Test Plan:
- Reset, then fill: WIDTH=8, DEPTH=4, AFULL=3, iReady_BM=0, push 0x11,0x22,0x33,0x44 on consecutive cycles. Required: oCount 1,2,3,4; oAlmostFull rises after the 3rd put; oReady_AM=0 after the 4th; a 5th push of 0x55 is held and not accepted.
- Drain from full: then iReady_BM=1 with no puts. Required: oData_BM reads 0x11,0x22,0x33,0x44 on four consecutive cycles; oValid_BM=0 after; oReady_AM back to 1 one cycle after the first get.
- Streaming: iValid_AM=iReady_BM=1 continuously, data counting 0..99. Required: after one-cycle latency, 100 outputs in order with no bubbles; oCount stays 1.
- Wrap-around with odd depth: DEPTH=3, random valid and ready (50%), 1000 beats. Required: scoreboard shows in-order, lossless output; oCount never exceeds 3; pointer wraps are exercised.
- Flush: count=2, then assert iFlush together with a put of 0xAA and a get. Required: next cycle oCount=0, oValid_BM=0, oReady_AM=1; 0xAA never appears at the output.
- Async reset mid-stream: assert iRST between clock edges at count=3. Required: oValid_BM=0, oReady_AM=1, oCount=0 before the next edge; after release, the first put appears one cycle later.
